// File: rtl/multaccel_bus_master.sv
// Initiator for the multiply accelerator's 8-bit peripheral bus (D/RWB/CE/A0).
// Turns single-beat load/fetch commands into timed CE cycles and returns fetched bytes.
module multaccel_bus_master #(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned TURNAROUND  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_load,
  input  logic       cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       busy,
  inout  wire  [7:0] D,
  output logic       RWB,
  output logic       CE,
  output logic       A0
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    TURN
  } state_t;

  localparam logic [3:0] LP_WAIT = 4'(WAIT_CYCLES);
  localparam logic [3:0] LP_TURN = (TURNAROUND > 0) ? 4'(TURNAROUND - 1) : 4'd0;

  state_t     r_state;
  logic [3:0] r_cnt;
  logic [7:0] r_wdata;
  logic       w_accept;
  logic       w_drive;

  assign cmd_ready = (r_state == IDLE) && !rst;
  assign busy      = (r_state != IDLE);
  assign w_accept  = cmd_valid && cmd_ready;

  // Drive only while the access is live; async reset leaves IDLE, releasing D at once.
  assign w_drive = (r_state == ACCESS) && RWB;
  assign D       = w_drive ? r_wdata : 8'bzzzz_zzzz;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_wdata   <= '0;
      CE        <= 1'b0;
      RWB       <= 1'b0;
      A0        <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_wdata <= cmd_wdata;
            CE      <= 1'b1;
            RWB     <= cmd_load;
            A0      <= cmd_addr;
            r_cnt   <= LP_WAIT;
            r_state <= ACCESS;
          end
        end
        ACCESS: begin
          if (r_cnt == '0) begin
            CE <= 1'b0;
            if (!RWB) begin
              // D is sampled on the edge that ends the last CE-high cycle.
              rsp_data  <= D;
              rsp_valid <= 1'b1;
              if (TURNAROUND > 0) begin
                r_cnt   <= LP_TURN;
                r_state <= TURN;
              end else begin
                r_state <= IDLE;
              end
            end else begin
              r_state <= IDLE;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        TURN: begin
          if (r_cnt == '0) begin
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multaccel_bus_master.sv
// Directed bench for multaccel_bus_master: three instances with different WAIT/TURN settings,
// each on its own bus with a two-register peripheral model and a pull-up on D.
module tb_multaccel_bus_master;

  localparam int NI = 3;
  localparam int W0 = 1, T0 = 1;
  localparam int W1 = 3, T1 = 2;
  localparam int W2 = 0, T2 = 1;

  int wait_p [NI] = '{W0, W1, W2};
  int turn_p [NI] = '{T0, T1, T2};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_load = 1'b0;
  logic       cmd_addr = 1'b0;
  logic [7:0] cmd_wdata = 8'h00;
  int         sel = 0;
  logic       p_ovr_en = 1'b0;
  logic [7:0] p_ovr = 8'h00;
  int         n_tests = 0;
  int         n_fail = 0;
  logic [7:0] last_rd [NI] = '{8'h00, 8'h00, 8'h00};

  wire [NI-1:0] ce_v, rwb_v, a0_v, rdy_v, rv_v, busy_v;
  wire [7:0]    rd_v [NI];
  wire [7:0]    d_v  [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int WP = (g == 0) ? W0 : (g == 1) ? W1 : W2;
    localparam int TP = (g == 0) ? T0 : (g == 1) ? T1 : T2;

    wire [7:0]  D;
    wire        ce, rwb, a0, rdy, rv, bsy;
    wire [7:0]  rd;
    logic [7:0] regs [2] = '{8'h00, 8'h00};
    wire [7:0]  pdrv = p_ovr_en ? p_ovr : regs[a0];

    for (genvar b = 0; b < 8; b++) begin : g_pu
      pullup (D[b]);
    end
    assign D = (ce && !rwb) ? pdrv : 8'bzzzz_zzzz;

    multaccel_bus_master #(.WAIT_CYCLES(WP), .TURNAROUND(TP)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid && (sel == g)),
      .cmd_ready (rdy),
      .cmd_load  (cmd_load),
      .cmd_addr  (cmd_addr),
      .cmd_wdata (cmd_wdata),
      .rsp_valid (rv),
      .rsp_data  (rd),
      .busy      (bsy),
      .D         (D),
      .RWB       (rwb),
      .CE        (ce),
      .A0        (a0)
    );

    always @(posedge clk) if (ce && rwb) regs[a0] <= D;

    assign ce_v[g]   = ce;
    assign rwb_v[g]  = rwb;
    assign a0_v[g]   = a0;
    assign rdy_v[g]  = rdy;
    assign rv_v[g]   = rv;
    assign busy_v[g] = bsy;
    assign rd_v[g]   = rd;
    assign d_v[g]    = D;

    // While the peripheral owns the bus, D must carry exactly what it drives.
    always begin
      @(negedge clk);
      #1;
      if (ce && !rwb) begin
        n_tests++;
        if (D !== pdrv) begin
          n_fail++;
          $display("FAIL k%0d bus contention: D=%02h expected %02h", g, D, pdrv);
        end
      end
    end
  end

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", nm, act, exp);
    end
  endtask

  task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h, expected %02h", nm, act, exp);
    end
  endtask

  task automatic do_cmd(input int k, input logic ld, input logic ad, input logic [7:0] wd,
                        input logic [7:0] exp_rd, input logic ovr,
                        input logic [7:0] early, input logic [7:0] lastv);
    int w, t, n;
    w = wait_p[k];
    t = turn_p[k];
    n = 0;
    while (rdy_v[k] !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk1($sformatf("k%0d ready before accept", k), rdy_v[k], 1'b1);
    sel       = k;
    cmd_valid = 1'b1;
    cmd_load  = ld;
    cmd_addr  = ad;
    cmd_wdata = wd;
    p_ovr_en  = ovr;
    p_ovr     = early;
    for (int i = 1; i <= w + 1; i++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      cmd_load  = ~ld;
      cmd_addr  = ~ad;
      cmd_wdata = ~wd;
      chk1($sformatf("k%0d CE c%0d", k, i), ce_v[k], 1'b1);
      chk1($sformatf("k%0d RWB c%0d", k, i), rwb_v[k], ld);
      chk1($sformatf("k%0d A0 c%0d", k, i), a0_v[k], ad);
      chk1($sformatf("k%0d ready c%0d", k, i), rdy_v[k], 1'b0);
      chk1($sformatf("k%0d rsp_valid c%0d", k, i), rv_v[k], 1'b0);
      chk1($sformatf("k%0d busy c%0d", k, i), busy_v[k], 1'b1);
      if (ld) chk8($sformatf("k%0d D c%0d", k, i), d_v[k], wd);
      p_ovr = (i == w + 1) ? lastv : early;
    end
    @(negedge clk);
    chk1($sformatf("k%0d CE end", k), ce_v[k], 1'b0);
    chk1($sformatf("k%0d rsp_valid end", k), rv_v[k], !ld);
    chk8($sformatf("k%0d D released", k), d_v[k], 8'hFF);
    chk1($sformatf("k%0d ready end", k), rdy_v[k], ld || (t == 0));
    chk1($sformatf("k%0d busy end", k), busy_v[k], !(ld || (t == 0)));
    if (!ld) begin
      chk8($sformatf("k%0d rsp_data", k), rd_v[k], exp_rd);
      last_rd[k] = exp_rd;
    end
    p_ovr_en = 1'b0;
    if (!ld) begin
      for (int j = 1; j < t; j++) begin
        @(negedge clk);
        chk1($sformatf("k%0d turn ready t%0d", k, j), rdy_v[k], 1'b0);
        chk1($sformatf("k%0d turn rsp_valid t%0d", k, j), rv_v[k], 1'b0);
        chk1($sformatf("k%0d turn CE t%0d", k, j), ce_v[k], 1'b0);
      end
    end
    @(negedge clk);
    chk1($sformatf("k%0d ready after", k), rdy_v[k], 1'b1);
    chk1($sformatf("k%0d rsp_valid after", k), rv_v[k], 1'b0);
    chk1($sformatf("k%0d CE after", k), ce_v[k], 1'b0);
    chk1($sformatf("k%0d busy after", k), busy_v[k], 1'b0);
    chk8($sformatf("k%0d rsp_data held", k), rd_v[k], last_rd[k]);
  endtask

  typedef struct {
    int         k;
    logic       ld;
    logic       ad;
    logic [7:0] wd;
    logic [7:0] exp_rd;
    logic       ovr;
    logic [7:0] early;
    logic [7:0] lastv;
  } vec_t;

  vec_t       tbl [12];
  logic [7:0] bytes [4];

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{0, 1'b1, 1'b0, 8'h2A, 8'h00, 1'b0, 8'h00, 8'h00};
    tbl[1]  = '{0, 1'b1, 1'b0, 8'h0C, 8'h00, 1'b0, 8'h00, 8'h00};
    tbl[2]  = '{0, 1'b1, 1'b1, 8'h0D, 8'h00, 1'b0, 8'h00, 8'h00};
    tbl[3]  = '{0, 1'b0, 1'b1, 8'h00, 8'h0D, 1'b0, 8'h00, 8'h00};
    tbl[4]  = '{0, 1'b0, 1'b0, 8'h00, 8'h0C, 1'b0, 8'h00, 8'h00};
    tbl[5]  = '{1, 1'b0, 1'b0, 8'h00, 8'hFF, 1'b1, 8'h33, 8'hFF};
    tbl[6]  = '{1, 1'b0, 1'b1, 8'h00, 8'h00, 1'b1, 8'h77, 8'h00};
    tbl[7]  = '{1, 1'b1, 1'b0, 8'h12, 8'h00, 1'b0, 8'h00, 8'h00};
    tbl[8]  = '{1, 1'b1, 1'b1, 8'h34, 8'h00, 1'b0, 8'h00, 8'h00};
    tbl[9]  = '{1, 1'b0, 1'b1, 8'h00, 8'h34, 1'b0, 8'h00, 8'h00};
    tbl[10] = '{1, 1'b0, 1'b0, 8'h00, 8'h12, 1'b0, 8'h00, 8'h00};
    tbl[11] = '{0, 1'b0, 1'b1, 8'h00, 8'h0D, 1'b0, 8'h00, 8'h00};
    bytes   = '{8'h00, 8'hFF, 8'h55, 8'hAA};

    // Reset state on every instance.
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      chk1($sformatf("k%0d rst CE", k), ce_v[k], 1'b0);
      chk1($sformatf("k%0d rst RWB", k), rwb_v[k], 1'b0);
      chk1($sformatf("k%0d rst A0", k), a0_v[k], 1'b0);
      chk1($sformatf("k%0d rst rsp_valid", k), rv_v[k], 1'b0);
      chk8($sformatf("k%0d rst rsp_data", k), rd_v[k], 8'h00);
      chk1($sformatf("k%0d rst ready", k), rdy_v[k], 1'b0);
      chk1($sformatf("k%0d rst busy", k), busy_v[k], 1'b0);
      chk8($sformatf("k%0d rst D", k), d_v[k], 8'hFF);
    end
    rst = 1'b0;
    @(negedge clk);
    chk1("k0 ready after rst", rdy_v[0], 1'b1);

    // Reset pulse in the middle of a load access.
    sel = 0; cmd_valid = 1'b1; cmd_load = 1'b1; cmd_addr = 1'b1; cmd_wdata = 8'h5A;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk1("midrst CE before", ce_v[0], 1'b1);
    chk8("midrst D before", d_v[0], 8'h5A);
    #2 rst = 1'b1;
    #1;
    chk1("midrst CE", ce_v[0], 1'b0);
    chk8("midrst D", d_v[0], 8'hFF);
    chk1("midrst ready", rdy_v[0], 1'b0);
    chk1("midrst busy", busy_v[0], 1'b0);
    chk1("midrst rsp_valid", rv_v[0], 1'b0);
    @(negedge clk);
    chk1("midrst rsp_valid held", rv_v[0], 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk1("midrst CE after", ce_v[0], 1'b0);
    chk1("midrst ready after", rdy_v[0], 1'b1);
    chk1("midrst rsp_valid after", rv_v[0], 1'b0);

    for (int i = 0; i < 12; i++) begin
      do_cmd(tbl[i].k, tbl[i].ld, tbl[i].ad, tbl[i].wd, tbl[i].exp_rd,
             tbl[i].ovr, tbl[i].early, tbl[i].lastv);
      if (i == 0) chk8("periph reg A", g_dut[0].regs[0], 8'h2A);
    end

    // WAIT_CYCLES=0 with cmd_valid held: CE toggles every cycle.
    sel = 2; cmd_valid = 1'b1; cmd_load = 1'b1; cmd_addr = 1'b0; cmd_wdata = bytes[0];
    chk1("b2b ready", rdy_v[2], 1'b1);
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      chk1($sformatf("b2b CE hi %0d", j), ce_v[2], 1'b1);
      chk1($sformatf("b2b RWB %0d", j), rwb_v[2], 1'b1);
      chk1($sformatf("b2b A0 %0d", j), a0_v[2], logic'(j % 2));
      chk8($sformatf("b2b D %0d", j), d_v[2], bytes[j]);
      if (j < 3) begin
        cmd_wdata = bytes[j+1];
        cmd_addr  = logic'((j + 1) % 2);
      end else begin
        cmd_valid = 1'b0;
      end
      @(negedge clk);
      chk1($sformatf("b2b CE lo %0d", j), ce_v[2], 1'b0);
      chk1($sformatf("b2b ready lo %0d", j), rdy_v[2], 1'b1);
      chk8($sformatf("b2b D lo %0d", j), d_v[2], 8'hFF);
    end
    @(negedge clk);
    chk1("b2b no extra CE", ce_v[2], 1'b0);
    chk1("b2b idle", busy_v[2], 1'b0);
    do_cmd(2, 1'b0, 1'b0, 8'h00, 8'h55, 1'b0, 8'h00, 8'h00);
    do_cmd(2, 1'b0, 1'b1, 8'h00, 8'hAA, 1'b0, 8'h00, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
